// File: rtl/apb_req_gen.sv
// Pseudo-random APB command generator: an IDLE/WAIT/GEN scheduler paced by an
// upstream LFSR feeds a small command FIFO whose head is offered downstream.
module apb_req_gen #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] lfsr_i,
    input  logic       req_ready,
    output logic       req_valid,
    output logic       req_write,
    output logic [2:0] req_addr,
    output logic [7:0] req_wdata,
    output logic       busy,
    output logic [7:0] issued_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        GEN
    } state_t;

    typedef struct packed {
        logic       write;
        logic [2:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    state_t        state;
    logic [1:0]    gap_cnt;
    logic [7:0]    seq_cnt;

    cmd_t          mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    cmd_t          head;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    // Full is judged on the pre-edge occupancy, so a same-cycle pop never frees a slot for the push.
    assign push       = (state == GEN) && !fifo_full;
    assign pop        = !fifo_empty && req_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            gap_cnt <= 2'd0;
            seq_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        gap_cnt <= lfsr_i[1:0];
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (!en)
                        state <= IDLE;
                    else if (gap_cnt == 2'd0)
                        state <= GEN;
                    else
                        gap_cnt <= gap_cnt - 2'd1;
                end
                GEN: begin
                    if (push) begin
                        seq_cnt <= seq_cnt + 8'd1;
                        if (en) begin
                            gap_cnt <= lfsr_i[1:0];
                            state   <= WAIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{write: lfsr_i[3], addr: lfsr_i[2:0], wdata: seq_cnt};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            issued_cnt <= 8'd0;
        else if (pop)
            issued_cnt <= issued_cnt + 8'd1;
    end

    assign head      = fifo_empty ? '0 : mem[rd_ptr];
    assign req_valid = !fifo_empty;
    assign req_write = head.write;
    assign req_addr  = head.addr;
    assign req_wdata = head.wdata;
    assign busy      = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_apb_req_gen.sv
// Self-checking bench for apb_req_gen: directed vector tables, hand-written
// reset/enable corner sequences, and a randomized run against a queue-based model.
module tb_apb_req_gen;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] lfsr_i;
    logic       req_ready;
    logic       req_valid;
    logic       req_write;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       busy;
    logic [7:0] issued_cnt;

    always #5 clk = ~clk;

    apb_req_gen #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .lfsr_i     (lfsr_i),
        .req_ready  (req_ready),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .issued_cnt (issued_cnt)
    );

    typedef struct {
        bit         rst_before;
        logic       en;
        logic [3:0] lfsr;
        logic       ready;
        logic       valid;
        logic       write;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic       busy;
        logic [7:0] issued;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a command queue plus a countdown to the next generation slot.
    logic [11:0] mq[$];
    bit          m_active;
    int          m_until;
    int          m_seq;
    int          m_issued;
    int          m_pushes;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic valid, input logic write,
                                 input logic [2:0] addr, input logic [7:0] wdata,
                                 input logic bsy, input logic [7:0] issued);
        check({tag, "_valid"}, 32'(req_valid), 32'(valid));
        if (valid) begin
            check({tag, "_write"}, 32'(req_write), 32'(write));
            check({tag, "_addr"},  32'(req_addr),  32'(addr));
            check({tag, "_wdata"}, 32'(req_wdata), 32'(wdata));
        end
        check({tag, "_busy"},   32'(busy),       32'(bsy));
        check({tag, "_issued"}, 32'(issued_cnt), 32'(issued));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},  32'(req_valid),  32'(0));
        check({tag, "_write"},  32'(req_write),  32'(0));
        check({tag, "_addr"},   32'(req_addr),   32'(0));
        check({tag, "_wdata"},  32'(req_wdata),  32'(0));
        check({tag, "_busy"},   32'(busy),       32'(0));
        check({tag, "_issued"}, 32'(issued_cnt), 32'(0));
    endtask

    task automatic model_reset();
        mq.delete();
        m_active = 1'b0;
        m_until  = 0;
        m_seq    = 0;
        m_issued = 0;
    endtask

    // Applies reset from a negedge and releases it on a later negedge.
    task automatic do_reset();
        reset     = 1'b0;
        en        = 1'b0;
        lfsr_i    = 4'd0;
        req_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        model_reset();
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One clock edge of the specified behaviour, using the inputs present at the edge.
    task automatic model_step();
        bit do_pop;
        bit do_push;
        do_pop  = (mq.size() != 0) && req_ready;
        do_push = 1'b0;
        if (!m_active) begin
            if (en) begin
                m_active = 1'b1;
                m_until  = int'(lfsr_i[1:0]) + 1;
            end
        end else if (m_until > 0) begin
            if (!en) m_active = 1'b0;
            else     m_until--;
        end else if (mq.size() < DEPTH) begin
            do_push = 1'b1;
            if (en) m_until = int'(lfsr_i[1:0]) + 1;
            else    m_active = 1'b0;
        end
        if (do_pop) begin
            void'(mq.pop_front());
            m_issued = (m_issued + 1) % 256;
        end
        if (do_push) begin
            mq.push_back({lfsr_i[3], lfsr_i[2:0], 8'(m_seq)});
            m_seq = (m_seq + 1) % 256;
            m_pushes++;
        end
    endtask

    vec_t vecs[$];

    initial begin
        reset     = 1'b0;
        en        = 1'b0;
        lfsr_i    = 4'd0;
        req_ready = 1'b0;
        m_pushes  = 0;

        // First command after reset with gap 2: visible after the 5th edge.
        for (int s = 1; s <= 5; s++)
            vecs.push_back('{rst_before: (s == 1), en: 1'b1, lfsr: 4'b1010, ready: 1'b0,
                             valid: (s == 5), write: 1'b1, addr: 3'b010, wdata: 8'h00,
                             busy: 1'b1, issued: 8'd0});
        // Zero gap fills the FIFO every 2nd cycle, then a held ready drains it in order.
        for (int s = 1; s <= 17; s++) begin
            if (s <= 12)
                vecs.push_back('{rst_before: (s == 1), en: 1'b1, lfsr: 4'b0000, ready: 1'b0,
                                 valid: (s >= 3), write: 1'b0, addr: 3'd0, wdata: 8'h00,
                                 busy: 1'b1, issued: 8'd0});
            else
                vecs.push_back('{rst_before: 1'b0, en: 1'b1, lfsr: 4'b0000, ready: 1'b1,
                                 valid: 1'b1, write: 1'b0, addr: 3'd0, wdata: 8'(s - 12),
                                 busy: 1'b1, issued: 8'(s - 12)});
        end

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            en        = vecs[i].en;
            lfsr_i    = vecs[i].lfsr;
            req_ready = vecs[i].ready;
            step();
            check_outputs($sformatf("vec%0d", i), vecs[i].valid, vecs[i].write, vecs[i].addr,
                          vecs[i].wdata, vecs[i].busy, vecs[i].issued);
        end

        // Enable dropped while waiting with one command buffered.
        do_reset();
        en = 1'b1; lfsr_i = 4'b0011; req_ready = 1'b0;
        repeat (5) step();
        check_outputs("en_drop_pre", 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 8'd0);
        step();
        check_outputs("en_drop_push", 1'b1, 1'b0, 3'd3, 8'h00, 1'b1, 8'd0);
        en = 1'b0;
        step();
        check_outputs("en_drop_idle", 1'b1, 1'b0, 3'd3, 8'h00, 1'b1, 8'd0);
        req_ready = 1'b1;
        step();
        check_outputs("en_drop_drain", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'd1);
        repeat (5) step();
        check_outputs("en_drop_quiet", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'd1);

        // Asynchronous reset with three commands buffered.
        do_reset();
        en = 1'b1; lfsr_i = 4'b0000; req_ready = 1'b0;
        repeat (7) step();
        check_outputs("async_pre", 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 8'd0);
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_mid");
        @(negedge clk);
        reset = 1'b1; en = 1'b1; lfsr_i = 4'b0101;
        repeat (3) step();
        check_outputs("async_post_wait", 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 8'd0);
        step();
        check_outputs("async_post_first", 1'b1, 1'b0, 3'd5, 8'h00, 1'b1, 8'd0);

        // Randomized run against the reference model.
        do_reset();
        m_pushes = 0;
        begin
            int ready_pct = 50;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                if (cyc % 64 == 0) begin
                    case ($urandom_range(0, 3))
                        0:       ready_pct = 0;
                        1:       ready_pct = 25;
                        2:       ready_pct = 50;
                        default: ready_pct = 100;
                    endcase
                end
                en        = ($urandom_range(0, 19) != 0);
                lfsr_i    = 4'($urandom);
                req_ready = ($urandom_range(0, 99) < ready_pct);
                @(posedge clk);
                model_step();
                @(negedge clk);
                if (mq.size() != 0)
                    check_outputs("rnd", 1'b1, mq[0][11], mq[0][10:8], mq[0][7:0], 1'b1,
                                  8'(m_issued));
                else
                    check_outputs("rnd", 1'b0, 1'b0, 3'd0, 8'h00, m_active, 8'(m_issued));
            end
        end
        check("rnd_push_volume", 32'(m_pushes >= 300), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
